// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler
// Shares one codec output path between NUM_VOICES sample sources. Each frame
// visits the voices round-robin, one slot per cycle, sums their signed
// samples in a widened accumulator, applies an arithmetic-shift attenuation,
// saturates to SAMPLE_W bits and issues a single write strobe to the codec
// controller once its output FIFO has space.
//
// Ports:
//   CLOCK_50          system clock
//   reset             asynchronous active-high reset
//   voice_en          per-voice enable mask
//   attn              attenuation, right shift of the sum by attn bits
//   voice_valid       voice i has a sample ready
//   voice_sample      packed samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_ready       accept strobe for the voice in the current slot
//   audio_out_allowed codec output FIFO has space
//   write_audio_out   one-cycle write strobe to the codec controller
//   mix_down          saturated mixed sample
//   busy              high while a frame is in progress
//   underrun_count    saturating count of enabled-but-not-valid slots
module audio_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 32
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic [NUM_VOICES-1:0]            voice_en,
    input  logic [1:0]                       attn,
    input  logic [NUM_VOICES-1:0]            voice_valid,
    input  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_sample,
    output logic [NUM_VOICES-1:0]            voice_ready,
    input  logic                             audio_out_allowed,
    output logic                             write_audio_out,
    output logic [SAMPLE_W-1:0]              mix_down,
    output logic                             busy,
    output logic [15:0]                      underrun_count
);

    localparam int unsigned SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'($signed({1'b0, {(SAMPLE_W-1){1'b1}}}));
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        ACC_W'($signed({1'b1, {(SAMPLE_W-1){1'b0}}}));
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SAT     = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t                    state;
    logic [SLOT_W-1:0]         slot;
    logic signed [ACC_W-1:0]   acc;

    logic signed [SAMPLE_W-1:0] samples [NUM_VOICES];
    logic signed [ACC_W-1:0]    cur_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic [SAMPLE_W-1:0]        sat_val;
    logic                       slot_take;
    logic                       slot_underrun;

    // Unpack the flat sample bus into per-voice signed words.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_unpack
        assign samples[g] = voice_sample[g*SAMPLE_W +: SAMPLE_W];
    end

    // Sign-extended sample of the voice in the current slot.
    assign cur_ext       = ACC_W'(samples[slot]);
    assign slot_take     = (state == COLLECT) && voice_en[slot] && voice_valid[slot];
    assign slot_underrun = (state == COLLECT) && voice_en[slot] && !voice_valid[slot];

    // Ready must coincide with the slot that consumes the sample, so it is
    // decoded from the current state and slot rather than registered.
    always_comb begin
        voice_ready = '0;
        if (slot_take) begin
            voice_ready[slot] = 1'b1;
        end
    end

    // Attenuate then clamp to the SAMPLE_W signed range.
    assign shifted = acc >>> attn;

    always_comb begin
        if (shifted > SAT_MAX) begin
            sat_val = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            sat_val = shifted[SAMPLE_W-1:0];
        end
    end

    assign write_audio_out = (state == WRITE) && audio_out_allowed;

    // Frame sequencer: IDLE -> COLLECT (one cycle per voice) -> SAT -> WRITE.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            slot           <= '0;
            acc            <= '0;
            mix_down       <= '0;
            busy           <= 1'b0;
            underrun_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (audio_out_allowed) begin
                        acc   <= '0;
                        slot  <= '0;
                        state <= COLLECT;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (slot_take) begin
                        acc <= acc + cur_ext;
                    end
                    if (slot_underrun && (underrun_count != 16'hFFFF)) begin
                        underrun_count <= underrun_count + 16'd1;
                    end
                    if (slot == LAST_SLOT) begin
                        state <= SAT;
                    end else begin
                        slot <= slot + SLOT_W'(1);
                    end
                end
                SAT: begin
                    mix_down <= sat_val;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (audio_out_allowed) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Directed bench for audio_voice_scheduler (NUM_VOICES=4, SAMPLE_W=32).
module tb_audio_voice_scheduler;

    logic         clk;
    logic         reset;
    logic [3:0]   voice_en;
    logic [1:0]   attn;
    logic [3:0]   voice_valid;
    logic [127:0] voice_sample;
    logic [3:0]   voice_ready;
    logic         audio_out_allowed;
    logic         write_audio_out;
    logic [31:0]  mix_down;
    logic         busy;
    logic [15:0]  underrun_count;

    int n_checks;
    int n_errors;

    audio_voice_scheduler #(.NUM_VOICES(4), .SAMPLE_W(32)) dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .voice_en          (voice_en),
        .attn              (attn),
        .voice_valid       (voice_valid),
        .voice_sample      (voice_sample),
        .voice_ready       (voice_ready),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .mix_down          (mix_down),
        .busy              (busy),
        .underrun_count    (underrun_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full frame triggered from IDLE; stall = WRITE cycles with allowed low.
    task automatic do_frame(input string tag, input logic [3:0] en, input logic [3:0] valid,
                            input logic [127:0] smp, input logic [1:0] a, input int stall,
                            input logic [31:0] exp_mix, input logic [15:0] exp_ur);
        logic [3:0] er;
        @(negedge clk);
        voice_en = en; voice_valid = valid; voice_sample = smp; attn = a;
        audio_out_allowed = 1'b1;
        check({tag, "/idle_busy"}, 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            er = (en & valid) & (4'b0001 << i);
            check($sformatf("%s/ready%0d", tag, i), 64'(voice_ready), 64'(er));
            check($sformatf("%s/wr_slot%0d", tag, i), 64'(write_audio_out), 64'd0);
        end
        @(negedge clk);
        check({tag, "/sat_ready"}, 64'(voice_ready), 64'd0);
        check({tag, "/sat_busy"}, 64'(busy), 64'd1);
        check({tag, "/sat_wr"}, 64'(write_audio_out), 64'd0);
        if (stall > 0) audio_out_allowed = 1'b0;
        @(negedge clk);
        for (int s = 0; s < stall; s++) begin
            check($sformatf("%s/stall_wr%0d", tag, s), 64'(write_audio_out), 64'd0);
            check($sformatf("%s/stall_busy%0d", tag, s), 64'(busy), 64'd1);
            check($sformatf("%s/stall_mix%0d", tag, s), 64'(mix_down), 64'(exp_mix));
            @(negedge clk);
        end
        audio_out_allowed = 1'b1;
        #1;
        check({tag, "/write"}, 64'(write_audio_out), 64'd1);
        check({tag, "/mix"}, 64'(mix_down), 64'(exp_mix));
        check({tag, "/underrun"}, 64'(underrun_count), 64'(exp_ur));
        @(negedge clk);
        audio_out_allowed = 1'b0;
        #1;
        check({tag, "/post_wr"}, 64'(write_audio_out), 64'd0);
        check({tag, "/post_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "/single_wr"}, 64'(write_audio_out), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        voice_en = 4'h0; voice_valid = 4'h0; voice_sample = '0; attn = 2'd0;
        audio_out_allowed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/mix", 64'(mix_down), 64'd0);
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/ready", 64'(voice_ready), 64'd0);
        check("rst/wr", 64'(write_audio_out), 64'd0);
        check("rst/ur", 64'(underrun_count), 64'd0);
        reset = 1'b0;

        do_frame("basic", 4'b1111, 4'b1111,
                 {32'sd25, 32'sd5, -32'sd30, 32'sd100}, 2'd0, 0, 32'd100, 16'd0);
        do_frame("pos_sat", 4'b0011, 4'b1111,
                 {32'd9, 32'd9, 32'h7FFFFFFF, 32'h7FFFFFFF}, 2'd0, 0, 32'h7FFFFFFF, 16'd0);
        do_frame("neg_sat", 4'b0101, 4'b1111,
                 {32'd5, 32'h80000000, 32'd5, 32'h80000000}, 2'd0, 0, 32'h80000000, 16'd0);
        do_frame("attn2", 4'b1111, 4'b1111,
                 {32'd400, 32'd400, 32'd400, 32'd400}, 2'd2, 0, 32'd400, 16'd0);
        do_frame("attn1_neg", 4'b0001, 4'b1111,
                 {32'd50, 32'd60, 32'd70, -32'sd7}, 2'd1, 0, 32'hFFFFFFFC, 16'd0);
        do_frame("underrun", 4'b1011, 4'b0011,
                 {32'd40, 32'd30, 32'd20, 32'd10}, 2'd0, 0, 32'd30, 16'd1);
        do_frame("all_off", 4'b0000, 4'b1111,
                 {32'd4, 32'd3, 32'd2, 32'd1}, 2'd0, 0, 32'd0, 16'd1);
        do_frame("bp", 4'b1111, 4'b1111,
                 {32'd4, 32'd3, 32'd2, 32'd1}, 2'd0, 10, 32'd10, 16'd1);
        do_frame("attn3_neg", 4'b1111, 4'b1111,
                 {-32'sd4, -32'sd4, -32'sd4, -32'sd4}, 2'd3, 0, 32'hFFFFFFFE, 16'd1);

        // Reset in the middle of COLLECT clears everything without a clock edge.
        @(negedge clk);
        voice_en = 4'b1111; voice_valid = 4'b0111;
        voice_sample = {32'd8, 32'd7, 32'd6, 32'd5};
        audio_out_allowed = 1'b1;
        repeat (3) @(negedge clk);
        check("mid/busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid/mix", 64'(mix_down), 64'd0);
        check("mid/busy", 64'(busy), 64'd0);
        check("mid/ready", 64'(voice_ready), 64'd0);
        check("mid/wr", 64'(write_audio_out), 64'd0);
        check("mid/ur", 64'(underrun_count), 64'd0);
        audio_out_allowed = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rel/busy%0d", k), 64'(busy), 64'd0);
            check($sformatf("rel/wr%0d", k), 64'(write_audio_out), 64'd0);
        end
        do_frame("after_rst", 4'b1111, 4'b1111,
                 {32'sd25, 32'sd5, -32'sd30, 32'sd100}, 2'd0, 0, 32'd100, 16'd0);

        // Preload the counter near its ceiling rather than running 65k frames.
        @(negedge clk);
        force dut.underrun_count = 16'hFFFD;
        #1;
        release dut.underrun_count;
        do_frame("ur_sat1", 4'b1111, 4'b0000,
                 {32'd1, 32'd1, 32'd1, 32'd1}, 2'd0, 0, 32'd0, 16'hFFFF);
        do_frame("ur_sat2", 4'b1011, 4'b0011,
                 {32'd40, 32'd30, 32'd20, 32'd10}, 2'd0, 0, 32'd30, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_voice_scheduler.md
Name: audio_voice_scheduler

Overview:
- Shares the single codec output path between NUM_VOICES sample sources (tone generators, sample players).
- Visits the voices round-robin, one per cycle, and sums their signed samples in a widened accumulator.
- Applies a switch-selected attenuation, saturates the result, and presents it as mix_down.
- Issues a one-cycle write_audio_out to the audio controller only when audio_out_allowed is high.

Parameters:
NUM_VOICES, 4, number of sample requesters (2..8)
SAMPLE_W, 32, signed sample width; matches the codec channel word

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset (driven from ~KEY[1] at top level)
voice_en  input  NUM_VOICES  per-voice enable (from SW)
attn  input  2  mix attenuation: arithmetic right shift of the sum by attn bits
voice_valid  input  NUM_VOICES  voice i has a sample ready
voice_sample  input  NUM_VOICES*SAMPLE_W  packed signed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W]
voice_ready  output  NUM_VOICES  one-cycle accept strobe for voice i
audio_out_allowed  input  1  codec output FIFO has space
write_audio_out  output  1  one-cycle write strobe to the codec controller
mix_down  output  SAMPLE_W  saturated mixed sample to both codec channels
busy  output  1  high whenever state != IDLE
underrun_count  output  16  count of enabled voices that were not valid in their slot; saturating

Behaviour:
- Reset (async, any state): state=IDLE; voice_ready=0; write_audio_out=0; mix_down=0; busy=0; underrun_count=0; accumulator=0; slot index=0.
- Accumulator width: SAMPLE_W+clog2(NUM_VOICES)+1, signed. Each voice sample is sign-extended before being added.
- State IDLE:
  - If audio_out_allowed=1, clear the accumulator, set slot=0 and go to COLLECT.
  - Otherwise stay in IDLE.
- State COLLECT, one cycle per slot i = 0..NUM_VOICES-1:
  - voice_en[i]=1 and voice_valid[i]=1: voice_ready[i]=1 for this cycle only, and voice_sample[i] is added to the accumulator.
  - voice_en[i]=1 and voice_valid[i]=0: add 0; underrun_count increments by 1, holding at 0xFFFF.
  - voice_en[i]=0: add 0; no ready strobe; no underrun.
  - voice_ready is never asserted outside the current slot. At most one bit of voice_ready is high in any cycle.
  - voice_en changes take effect at the slot being evaluated in that cycle.
  - After the last slot, go to SAT.
- State SAT (1 cycle):
  - shifted = accumulator >>> attn, using attn sampled in this cycle.
  - mix_down is loaded with shifted clamped to the range [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Go to WRITE.
- State WRITE:
  - write_audio_out = audio_out_allowed, driven combinationally from the state register.
  - If audio_out_allowed=1, the write happens and the next state is IDLE.
  - Otherwise wait in WRITE indefinitely with mix_down held.
- mix_down is stable from the end of SAT until the next SAT, so it is valid while write_audio_out is high.
- Latency: from the IDLE cycle with audio_out_allowed=1, write_audio_out is asserted NUM_VOICES+2 cycles later at the earliest (6 cycles for NUM_VOICES=4).
- Frame spacing: back-to-back frames are NUM_VOICES+3 cycles apart, because IDLE always lasts at least one cycle.
- busy is a registered decode of the state: 1 in COLLECT, SAT and WRITE; 0 in IDLE.
- All voices disabled: the frame still runs and writes mix_down=0.
- Reset asserted mid-frame: the partial sum is discarded and no write is issued. After reset release the block starts cleanly from IDLE.

Test Plan:
- Reset check: hold reset mid-COLLECT -> all outputs 0 immediately (asynchronously); after release, busy=0 and no write until audio_out_allowed=1.
- Basic mix: N=4, all enabled and valid, samples 100, -30, 5, 25, attn=0, allowed=1 -> voice_ready pulses bits 0,1,2,3 on consecutive cycles; mix_down=100; write_audio_out high for 1 cycle exactly 6 cycles after the trigger.
- Positive saturation: two enabled voices at 0x7FFFFFFF, others disabled -> mix_down=0x7FFFFFFF.
- Negative saturation: two enabled voices at 0x80000000, others disabled -> mix_down=0x80000000.
- Attenuation: samples 400, 400, 400, 400 with attn=2 -> mix_down=400. Single voice -7 with attn=1 -> mix_down=-4 (arithmetic shift).
- Underrun and enable mask: voice_en=4'b1011 and voice_valid=4'b0011 -> no ready to voices 2 or 3; underrun_count increments by 1 (voice 3); mix_down=sum of voices 0 and 1. After 65540 such frames, underrun_count stays at 0xFFFF.
- Backpressure: drop audio_out_allowed in SAT and hold it low for 10 cycles -> state stays WRITE, busy=1, write_audio_out=0, mix_down constant; exactly one write when allowed returns, then IDLE.
